// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encoding and op legality for the iterative multiply/divide unit.
// Contents: OP_* op codes, state_t (ST_IDLE/ST_CALC/ST_FIX), DW_DEFAULT, op_legal().
// Build option: MDU_MADD_EN makes MADD/MADDU (100/101) legal ops.
package mdu_pkg;
    localparam int DW_DEFAULT = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;
    function automatic logic op_legal(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return op <= OP_MADDU;
`else
        return op <= OP_DIVU;
`endif
    endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide step on a {rem, quo} pair.
// Ports: rem_in/quo_in current partial remainder and dividend/quotient shift register,
//        divisor magnitude, rem_out/quo_out state after shifting in one dividend bit.
module mdu_div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_in,
    input  logic [DW-1:0] quo_in,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_out,
    output logic [DW-1:0] quo_out
);
    logic [DW:0] shifted;
    logic [DW:0] diff;
    assign shifted = {rem_in, quo_in[DW-1]};
    // bit DW of diff set means the trial subtraction went negative: restore
    assign diff    = shifted - {1'b0, divisor};
    assign rem_out = diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
    assign quo_out = {quo_in[DW-2:0], ~diff[DW]};
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding the HI/LO registers.
// Ports: clk, rst (async, active-high); start/op/a/b request (sampled in IDLE);
//        hi_in/lo_in accumulate operand for MADD ops; busy while in flight; done one-cycle
//        HI/LO write strobe; hi_out/lo_out result (held until next completion);
//        div_zero set with done when a divide had b==0, cleared on next accepted start.
// Build option: MDU_MADD_EN adds MADD/MADDU (product + {hi_in, lo_in} sampled at start).
module mdu_iter import mdu_pkg::*; #(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] hi_in,
    input  logic [DW-1:0] lo_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi_out,
    output logic [DW-1:0] lo_out,
    output logic          div_zero
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2*DW-1:0] acc;
    logic [DW-1:0] mcand;
    logic is_div, neg_p, neg_r, dz;
    logic accept, last, a_neg, b_neg;
    logic [DW-1:0] a_abs, b_abs, rem_nx, quo_nx, rem_fix, quo_fix;
    logic [DW:0] add_sum;
    logic [2*DW-1:0] prod, prod_fix;
`ifdef MDU_MADD_EN
    logic [2*DW-1:0] addend;
`else
    logic unused_madd;
    assign unused_madd = ^{hi_in, lo_in};
`endif

    // op[0]==0 marks the signed variants (MULT/DIV/MADD); op[1] selects divide
    assign a_neg  = ~op[0] & a[DW-1];
    assign b_neg  = ~op[0] & b[DW-1];
    assign a_abs  = a_neg ? -a : a;
    assign b_abs  = b_neg ? -b : b;
    assign accept = state == ST_IDLE && start && op_legal(op);
    assign last   = cnt == CNT_W'(DW - 1);

    mdu_div_step #(.DW(DW)) u_div_step (
        .rem_in  (acc[2*DW-1:DW]),
        .quo_in  (acc[DW-1:0]),
        .divisor (mcand),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // shift-add: low half holds the unconsumed multiplier bits, high half the partial product
    assign add_sum = {1'b0, acc[2*DW-1:DW]} + {1'b0, acc[0] ? mcand : {DW{1'b0}}};

    always_comb begin
        prod    = neg_p ? -acc : acc;
`ifdef MDU_MADD_EN
        prod_fix = prod + addend;
`else
        prod_fix = prod;
`endif
        // divide by zero leaves rem == |a|; restoring the dividend sign returns a unmodified
        quo_fix = dz ? {DW{1'b1}} : (neg_p ? -acc[DW-1:0] : acc[DW-1:0]);
        rem_fix = neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == ST_IDLE ? (accept ? ST_CALC : ST_IDLE) :
                   state == ST_CALC ? (last ? ST_FIX : ST_CALC) : ST_IDLE;
    end

    always_comb begin
        busy = state != ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_zero <= 1'b0;
`ifdef MDU_MADD_EN
            addend   <= '0;
`endif
        end else begin
            done <= state == ST_FIX;
            if (accept) begin
                cnt      <= '0;
                is_div   <= op[1];
                neg_p    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                dz       <= op[1] && b == '0;
                mcand    <= op[1] ? b_abs : a_abs;
                acc      <= {{DW{1'b0}}, op[1] ? a_abs : b_abs};
                div_zero <= 1'b0;
`ifdef MDU_MADD_EN
                addend   <= {hi_in, lo_in};
`endif
            end else if (state == ST_CALC) begin
                cnt <= last ? cnt : cnt + 1'b1;
                acc <= is_div ? {rem_nx, quo_nx} : {add_sum, acc[DW-1:1]};
            end else if (state == ST_FIX) begin
                hi_out   <= is_div ? rem_fix : prod_fix[2*DW-1:DW];
                lo_out   <= is_div ? quo_fix : prod_fix[DW-1:0];
                div_zero <= dz;
            end
        end
    end
endmodule
